regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_scoreboard.sv | 82 ++++++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the write-port priority encoder for the register file.
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_NREGS);

    // Upper bounds for the priority encoder arguments; narrower instances zero-extend.
    localparam int MAX_NWR = 8;
    localparam int MAX_AW  = 16;

    typedef logic [DEFAULT_AW-1:0] reg_idx_t;

    // Index of the highest-numbered enabled write port targeting addr, or -1 if none.
    function automatic int wr_winner(
        input logic [MAX_NWR-1:0] en,
        input logic [MAX_AW-1:0]  addrs [MAX_NWR],
        input logic [MAX_AW-1:0]  addr
    );
        int win;
        win = -1;
        for (int j = 0; j < MAX_NWR; j++) begin
            if (en[j] && (addrs[j] == addr)) begin
                win = j;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: set on issue, cleared on write-back, squashed on flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush
);

    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;
    logic [MAX_NWR-1:0] wen_ext;
    logic [MAX_AW-1:0]  wa_ext [MAX_NWR];

    // Widen the write ports to the encoder's fixed argument shape.
    always_comb begin
        wen_ext = '0;
        for (int j = 0; j < MAX_NWR; j++) begin
            wa_ext[j] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            wen_ext[j] = wr_en[j];
            wa_ext[j]  = MAX_AW'(wr_addr[j*AW +: AW]);
        end
    end

    // Next busy state: write-back clears, flush clears everything, issue sets last so it wins.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (wr_winner(wen_ext, wa_ext, MAX_AW'(r)) >= 0) begin
                busy_d[r] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        if (iss_valid && !((ZERO_REG != 0) && (iss_rd == '0))) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    // Busy register; reset clears it and discards same-cycle issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy read muxes; a same-cycle write-back hides the stale busy bit when bypassing.
    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        a       = '0;
        hit     = 1'b0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            a          = rd_addr[i*AW +: AW];
            hit        = (wr_winner(wen_ext, wa_ext, MAX_AW'(a)) >= 0);
            rd_busy[i] = busy_q[a] & ~((BYPASS != 0) && hit);
            if (rst || ((ZERO_REG != 0) && (a == '0))) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle bypass and a write-back scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush
);

    logic [XLEN-1:0]    mem [NREGS];
    logic [MAX_NWR-1:0] wen_ext;
    logic [MAX_AW-1:0]  wa_ext [MAX_NWR];

    // Widen the write ports to the encoder's fixed argument shape.
    always_comb begin
        wen_ext = '0;
        for (int j = 0; j < MAX_NWR; j++) begin
            wa_ext[j] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            wen_ext[j] = wr_en[j];
            wa_ext[j]  = MAX_AW'(wr_addr[j*AW +: AW]);
        end
    end

    // Array update; ports are applied in ascending order so the highest index lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0))) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes: zero register, then the winning same-cycle write, then the array.
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] word;
        int              win;
        a       = '0;
        word    = '0;
        win     = -1;
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            a    = rd_addr[i*AW +: AW];
            win  = wr_winner(wen_ext, wa_ext, MAX_AW'(a));
            word = mem[a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (win == j) begin
                        word = wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (rst || ((ZERO_REG != 0) && (a == '0))) begin
                word = '0;
            end
            rd_data[i*XLEN +: XLEN] = word;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on / off) driven in lockstep against a reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AWB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    rd_addr;
    logic [63:0]   rd_data, rd_data_nb;
    logic [1:0]    rd_busy, rd_busy_nb;
    logic [1:0]    wr_en;
    logic [9:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic          flush;

    logic [31:0]   m_mem [NR];
    bit            m_busy [NR];
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
    );

    regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_data(reg_idx_t a, bit byp);
        logic [31:0] v;
        if (rst || a == 0) return 32'h0;
        v = m_mem[a];
        if (byp) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*AWB +: AWB] == a) v = wr_data[j*XL +: XL];
        end
        return v;
    endfunction

    function automatic bit exp_busy(reg_idx_t a, bit byp);
        if (rst || a == 0) return 1'b0;
        if (byp) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*AWB +: AWB] == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    task automatic model_clock();
        reg_idx_t wa;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r] = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                wa = wr_addr[j*AWB +: AWB];
                if (wr_en[j]) begin
                    if (wa != 0) m_mem[wa] = wr_data[j*XL +: XL];
                    m_busy[wa] = 1'b0;
                end
            end
            if (flush)
                for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wr_en = 2'b00;
        iss_valid = 1'b0;
        flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        wr_en = 2'b11;
        wr_addr = {5'd3, 5'd4};
        wr_data = {32'h1111_2222, 32'h3333_4444};
        iss_valid = 1'b1;
        iss_rd = 5'd4;
        rd_addr = {5'd3, 5'd4};
        #1;
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (rd_data[i*XL +: XL] !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold_data port%0d: got %h expected 0", i, rd_data[i*XL +: XL]);
            end
            if (rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_busy port%0d: got %b expected 0", i, rd_busy[i]);
            end
        end
        tick();
        tick();
        idle();
        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            for (int i = 0; i < 2; i++) begin
                checks += 4;
                if (rd_data[i*XL +: XL] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data r%0d: got %h expected 0", a + i, rd_data[i*XL +: XL]);
                end
                if (rd_data_nb[i*XL +: XL] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data_nb r%0d: got %h expected 0", a + i, rd_data_nb[i*XL +: XL]);
                end
                if (rd_busy[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy r%0d: got %b expected 0", a + i, rd_busy[i]);
                end
                if (rd_busy_nb[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy_nb r%0d: got %b expected 0", a + i, rd_busy_nb[i]);
                end
            end
        end
    endtask

    task automatic test_write_x0();
        idle();
        wr_en = 2'b11;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0000_1234, 32'hDEAD_BEEF};
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        checks += 4;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_r5: got %h expected deadbeef", rd_data[31:0]);
        end
        if (rd_data_nb[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_r5_nb: got %h expected deadbeef", rd_data_nb[31:0]);
        end
        if (rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL write_r0: got %h expected 0", rd_data[63:32]);
        end
        if (rd_data_nb[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL write_r0_nb: got %h expected 0", rd_data_nb[63:32]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'hA5A5_A5A5};
        rd_addr = {5'd7, 5'd7};
        #1;
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (rd_data[i*XL +: XL] !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL bypass_data port%0d: got %h expected a5a5a5a5", i, rd_data[i*XL +: XL]);
            end
            if (rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL bypass_busy port%0d: got %b expected 0", i, rd_busy[i]);
            end
            if (rd_data_nb[i*XL +: XL] !== 32'h0) begin
                errors++;
                $display("FAIL nobypass_data port%0d: got %h expected 0", i, rd_data_nb[i*XL +: XL]);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_conflict();
        idle();
        wr_en = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h2, 32'h1};
        tick();
        idle();
        rd_addr = {5'd9, 5'd9};
        #1;
        checks += 2;
        if (rd_data[31:0] !== 32'h2) begin
            errors++;
            $display("FAIL conflict_r9: got %h expected 2", rd_data[31:0]);
        end
        if (rd_data_nb[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL conflict_r9_nb: got %h expected 2", rd_data_nb[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {5'd3, 5'd3};
        iss_valid = 1'b1;
        iss_rd = 5'd3;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue_same_cycle: got %b expected 0", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks += 2;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issued: got %b expected 1", rd_busy[0]);
        end
        if (rd_busy_nb[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issued_nb: got %b expected 1", rd_busy_nb[0]);
        end
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'h0000_0033};
        iss_valid = 1'b1;
        iss_rd = 5'd3;
        #1;
        checks += 2;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_wb_masked: got %b expected 0", rd_busy[0]);
        end
        if (rd_busy_nb[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_wb_nb: got %b expected 1", rd_busy_nb[0]);
        end
        tick();
        idle();
        #1;
        checks += 2;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_beats_clear: got %b expected 1", rd_busy[0]);
        end
        if (rd_busy_nb[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_beats_clear_nb: got %b expected 1", rd_busy_nb[0]);
        end
        wr_en = 2'b10;
        wr_addr = {5'd3, 5'd0};
        wr_data = {32'h0000_0044, 32'h0};
        tick();
        idle();
        #1;
        checks += 3;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: got %b expected 0", rd_busy[0]);
        end
        if (rd_busy_nb[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared_nb: got %b expected 0", rd_busy_nb[0]);
        end
        if (rd_data[31:0] !== 32'h0000_0044) begin
            errors++;
            $display("FAIL sb_wb_data: got %h expected 44", rd_data[31:0]);
        end
    endtask

    task automatic test_flush();
        idle();
        iss_valid = 1'b1;
        iss_rd = 5'd4;  tick();
        iss_rd = 5'd6;  tick();
        iss_rd = 5'd8;  tick();
        flush = 1'b1;
        iss_rd = 5'd10; tick();
        idle();
        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            for (int i = 0; i < 2; i++) begin
                checks += 2;
                if (rd_busy[i] !== ((a + i) == 10)) begin
                    errors++;
                    $display("FAIL flush_busy r%0d: got %b expected %b", a + i, rd_busy[i], (a + i) == 10);
                end
                if (rd_busy_nb[i] !== ((a + i) == 10)) begin
                    errors++;
                    $display("FAIL flush_busy_nb r%0d: got %b expected %b", a + i, rd_busy_nb[i], (a + i) == 10);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rst = 1'b1;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd2};
        wr_data = {32'h0, 32'h0000_00FF};
        iss_valid = 1'b1;
        iss_rd = 5'd12;
        tick();
        idle();
        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            for (int i = 0; i < 2; i++) begin
                checks += 3;
                if (rd_data[i*XL +: XL] !== 32'h0) begin
                    errors++;
                    $display("FAIL rstmid_data r%0d: got %h expected 0", a + i, rd_data[i*XL +: XL]);
                end
                if (rd_busy[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_busy r%0d: got %b expected 0", a + i, rd_busy[i]);
                end
                if (rd_busy_nb[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_busy_nb r%0d: got %b expected 0", a + i, rd_busy_nb[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        reg_idx_t a;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 15) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd = 5'($urandom_range(0, 31));
            wr_en = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                wr_addr[j*AWB +: AWB] = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
                wr_data[j*XL +: XL] = $urandom;
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0)
                    rd_addr[i*AWB +: AWB] = wr_addr[($urandom_range(0, 1))*AWB +: AWB];
                else
                    rd_addr[i*AWB +: AWB] = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                a = rd_addr[i*AWB +: AWB];
                checks += 4;
                if (rd_data[i*XL +: XL] !== exp_data(a, 1'b1)) begin
                    errors++;
                    $display("FAIL rand_data cyc%0d port%0d r%0d: got %h expected %h", n, i, a, rd_data[i*XL +: XL], exp_data(a, 1'b1));
                end
                if (rd_data_nb[i*XL +: XL] !== exp_data(a, 1'b0)) begin
                    errors++;
                    $display("FAIL rand_data_nb cyc%0d port%0d r%0d: got %h expected %h", n, i, a, rd_data_nb[i*XL +: XL], exp_data(a, 1'b0));
                end
                if (rd_busy[i] !== exp_busy(a, 1'b1)) begin
                    errors++;
                    $display("FAIL rand_busy cyc%0d port%0d r%0d: got %b expected %b", n, i, a, rd_busy[i], exp_busy(a, 1'b1));
                end
                if (rd_busy_nb[i] !== exp_busy(a, 1'b0)) begin
                    errors++;
                    $display("FAIL rand_busy_nb cyc%0d port%0d r%0d: got %b expected %b", n, i, a, rd_busy_nb[i], exp_busy(a, 1'b0));
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_rd = '0;
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = 32'h0;
            m_busy[r] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write_x0();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
